store_drain_scheduler: RTL

STORE_DRAIN_SCHEDULER -- requirements
Module: store_drain_scheduler

---
 rtl/store_drain_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/store_drain_scheduler.sv
// store_drain_scheduler
//   Drains committed stores from the store queue head into the DCache one at a
//   time. It tracks how many committed stores are still undrained, issues a write
//   request for the head entry, and waits on an MSHR refill when a write misses.
//   A failed store-conditional at the head is released without any write.
//
//   Optional build macro: RSD_STORE_DRAIN_WATCHDOG_EN
//     When it is defined, an 8-bit counter bounds the time spent in WAIT_MSHR.
//     On expiry the FSM retries the write and pulses watchdogFire.
//     When it is undefined, WAIT_MSHR waits for the refill with no time limit and
//     watchdogFire is tied to 0.
//
//   Ports
//     clk, rst                        clock, asynchronous active-high reset
//     commitStore, commitStoreNum     stores committed this cycle and how many
//     storeQueueHeadPtr               current SQ head index
//     retiredStoreCondEnabled         head store writes (0 = failed SC, skip it)
//     dcWriteReqAck, dcWriteHit       DCache accepted the write, and whether it hit
//     storeHasAllocatedMSHR           a write that missed got an MSHR
//     storeMSHRID                     id of that MSHR
//     mshrFillDone                    per-MSHR refill-complete pulses
//     dcWriteReq                      write request to the DCache
//     retiredStoreQueuePtr            SQ entry being drained
//     releaseStoreQueueHead[EntryNum] release the SQ head (always 1 entry)
//     busyInRecovery, pendingCount    committed stores not yet drained
//     watchdogFire                    one-cycle pulse on an MSHR wait timeout
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no undrained committed stores
//   REQ       | head store is presented to the DCache (or skipped if SC failed)
//   WAIT_MSHR | write missed; waiting for the refill of the latched MSHR
module store_drain_scheduler #(
    parameter int SQ_INDEX_WIDTH     = 4,
    parameter int COMMIT_COUNT_WIDTH = 2,
    parameter int MSHR_NUM           = 2,
    localparam int MSHR_ID_WIDTH     = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          commitStore,
    input  logic [COMMIT_COUNT_WIDTH-1:0] commitStoreNum,
    input  logic [SQ_INDEX_WIDTH-1:0]     storeQueueHeadPtr,
    input  logic                          retiredStoreCondEnabled,
    input  logic                          dcWriteReqAck,
    input  logic                          dcWriteHit,
    input  logic                          storeHasAllocatedMSHR,
    input  logic [MSHR_ID_WIDTH-1:0]      storeMSHRID,
    input  logic [MSHR_NUM-1:0]           mshrFillDone,
    output logic                          dcWriteReq,
    output logic [SQ_INDEX_WIDTH-1:0]     retiredStoreQueuePtr,
    output logic                          releaseStoreQueueHead,
    output logic [COMMIT_COUNT_WIDTH-1:0] releaseStoreQueueHeadEntryNum,
    output logic                          busyInRecovery,
    output logic [SQ_INDEX_WIDTH:0]       pendingCount,
    output logic                          watchdogFire
);

    // Two spare bits so an over-commit is still visible to the assertion below.
    localparam int CALC_W = SQ_INDEX_WIDTH + 2;
    localparam logic [CALC_W-1:0] SQ_DEPTH = CALC_W'(2 ** SQ_INDEX_WIDTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_MSHR = 2'd2
    } state_t;

    state_t                     state;
    state_t                     nextState;
    logic [SQ_INDEX_WIDTH:0]    pendingCountQ;
    logic [MSHR_ID_WIDTH-1:0]   mshrIdQ;
    logic [CALC_W-1:0]          commitAdd;
    logic [CALC_W-1:0]          pendingNext;
    logic                       reqInt;
    logic                       releaseInt;
    logic                       missAllocated;
    logic                       fillSeen;
    logic                       wdExpire;

    // Request and release decode: depends only on state and inputs, kept apart
    // from the next-state logic so the pending-count update feeds it cleanly.
    always_comb begin
        reqInt        = 1'b0;
        releaseInt    = 1'b0;
        missAllocated = 1'b0;
        if (state == REQ) begin
            if (!retiredStoreCondEnabled) begin
                releaseInt = 1'b1;
            end else begin
                reqInt = 1'b1;
                if (dcWriteReqAck) begin
                    releaseInt    = dcWriteHit;
                    missAllocated = !dcWriteHit && storeHasAllocatedMSHR;
                end
            end
        end
    end

    assign commitAdd   = commitStore ? CALC_W'(commitStoreNum) : '0;
    assign pendingNext = CALC_W'(pendingCountQ) + commitAdd - CALC_W'(releaseInt);
    assign fillSeen    = mshrFillDone[mshrIdQ];

`ifdef RSD_STORE_DRAIN_WATCHDOG_EN
    logic [7:0] wdCount;

    // The counter sits at 0 outside WAIT_MSHR, so it reads 0 on the first cycle
    // in that state and 255 on the 256th; the timeout is taken on that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdCount <= '0;
        end else if (state != WAIT_MSHR) begin
            wdCount <= '0;
        end else begin
            wdCount <= wdCount + 8'd1;
        end
    end

    assign wdExpire     = (state == WAIT_MSHR) && (wdCount == 8'hFF);
    // A refill arriving on the expiry cycle wins; no timeout is reported.
    assign watchdogFire = wdExpire && !fillSeen;
`else
    assign wdExpire     = 1'b0;
    assign watchdogFire = 1'b0;
`endif

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                // Commit in this cycle already counts, giving one-cycle latency.
                if (pendingNext != '0) nextState = REQ;
            end
            REQ: begin
                if (releaseInt) begin
                    nextState = (pendingNext == '0) ? IDLE : REQ;
                end else if (missAllocated) begin
                    nextState = WAIT_MSHR;
                end
            end
            WAIT_MSHR: begin
                if (fillSeen || wdExpire) nextState = REQ;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pendingCountQ <= '0;
            mshrIdQ       <= '0;
        end else begin
            state         <= nextState;
            pendingCountQ <= pendingNext[SQ_INDEX_WIDTH:0];
            if (missAllocated) mshrIdQ <= storeMSHRID;
        end
    end

    assign dcWriteReq                    = reqInt;
    assign retiredStoreQueuePtr          = (state == REQ) ? storeQueueHeadPtr : '0;
    assign releaseStoreQueueHead         = releaseInt;
    assign releaseStoreQueueHeadEntryNum = COMMIT_COUNT_WIDTH'(releaseInt);
    assign pendingCount                  = pendingCountQ;
    assign busyInRecovery                = (pendingCountQ != '0);

    // Committing past the store queue depth is an upstream bug.
    pendingOverflow: assert property (@(posedge clk) disable iff (rst)
        pendingNext <= SQ_DEPTH)
        else $error("store_drain_scheduler: pending store count exceeds SQ depth");

endmodule
